led_blink_signaler: RTL and testbench



---
 rtl/led_signaler_pkg.sv | 38 +++
 rtl/led_blink_signaler_phase_timer.sv | 50 +++++
 rtl/led_blink_signaler.sv | 181 ++++++++++++++++++
 tb/tb_led_blink_signaler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_signaler_pkg.sv
// Shared definitions for the LED blink signaler.
// Contents:
//   state_e    - sequencer states (idle, lit phase, dark phase, repeat gap)
//   ms_to_clks - converts a millisecond phase length into clock cycles,
//                never returning fewer than one cycle
//   max3       - largest of three values, used to size the phase timer
package led_signaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // A zero-length phase still occupies one clock, so the sequencer always
  // visits every state it passes through.
  function automatic int unsigned ms_to_clks(input int unsigned freq,
                                             input int unsigned ms);
    int unsigned clks;
    clks = (freq / 1000) * ms;
    if (clks == 0) begin
      clks = 1;
    end
    return clks;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/led_blink_signaler_phase_timer.sv
// Loadable down-counter that times one sequencer phase.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load        - start a new phase; has priority over counting
//   load_value  - phase length minus one, in clocks
//   expire      - high for one cycle, in the last cycle of the phase
// A phase loaded with value N lasts N+1 cycles, counting the cycle after
// the load as the first one.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             active_q, active_d;

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = load_value;
      active_d = 1'b1;
    end else if (active_q) begin
      // The timer stops itself after expiring so expire is a single pulse.
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign expire = active_q && (count_q == '0);

endmodule

// File: rtl/led_blink_signaler.sv
// LED blink signaler: accepts blink requests on a valid/ready handshake and
// drives one LED with a timed sequence of blinks, one-shot or repeating,
// with PWM brightness control.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   req_valid       - request strobe
//   req_ready       - request accepted this cycle if req_valid is high
//   req_count       - number of blinks; 0 stops the LED
//   req_repeat      - 1 = loop the sequence forever with a gap in between
//   req_brightness  - lit duty cycle; all-ones is fully on
//   led             - registered LED drive
//   busy            - a sequence is in progress
//   done            - one-cycle pulse after the last blink of a one-shot
module led_blink_signaler
  import led_signaler_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY    = 100000000,
  parameter logic        LED_OUTPUT_LEVEL = 1'b1,
  parameter int unsigned ON_MS            = 200,
  parameter int unsigned OFF_MS           = 200,
  parameter int unsigned GAP_MS           = 1000,
  parameter int          CNT_W            = 4,
  parameter int          PWM_W            = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic             req_repeat,
  input  logic [PWM_W-1:0] req_brightness,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ON_CLKS  = ms_to_clks(CLK_FREQUENCY, ON_MS);
  localparam int unsigned OFF_CLKS = ms_to_clks(CLK_FREQUENCY, OFF_MS);
  localparam int unsigned GAP_CLKS = ms_to_clks(CLK_FREQUENCY, GAP_MS);
  localparam int unsigned MAX_CLKS = max3(ON_CLKS, OFF_CLKS, GAP_CLKS);
  localparam int          TIMER_W  = $clog2(MAX_CLKS + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CLKS - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CLKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CLKS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               repeat_q, repeat_d;
  logic [PWM_W-1:0]   bright_q, bright_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               led_q, led_d;
  logic               done_q, done_d;

  logic               accept;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expire;

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (timer_expire)
  );

  // A repeating sequence never ends by itself, so it stays interruptible;
  // a one-shot must run to completion.
  assign req_ready = (state_q == ST_IDLE) || repeat_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    repeat_d    = repeat_q;
    bright_d    = bright_q;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    done_d      = 1'b0;
    timer_load  = 1'b0;
    timer_value = ON_LOAD;

    // remaining counts the blinks still to come after the current one.
    unique case (state_q)
      ST_ON: begin
        if (timer_expire) begin
          state_d     = ST_OFF;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (timer_expire) begin
          if (remaining_q != '0) begin
            state_d     = ST_ON;
            remaining_d = remaining_q - 1'b1;
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end else if (repeat_q) begin
            state_d     = ST_GAP;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (timer_expire) begin
          state_d     = ST_ON;
          remaining_d = count_q - 1'b1;
          timer_load  = 1'b1;
          timer_value = ON_LOAD;
        end
      end
      default: begin
      end
    endcase

    // An accepted request overrides whatever the sequence was doing; done
    // can never coincide because a one-shot in progress is not ready.
    if (accept) begin
      done_d = 1'b0;
      if (req_count != '0) begin
        state_d     = ST_ON;
        count_d     = req_count;
        remaining_d = req_count - 1'b1;
        repeat_d    = req_repeat;
        bright_d    = req_brightness;
        timer_load  = 1'b1;
        timer_value = ON_LOAD;
      end else begin
        state_d     = ST_IDLE;
        count_d     = '0;
        remaining_d = '0;
        repeat_d    = 1'b0;
        bright_d    = '0;
      end
    end

    // LED is computed from next-cycle values so the flop output matches the
    // state and PWM counter of the cycle it is visible in.
    if ((state_d == ST_ON) && ((bright_d == '1) || (pwm_cnt_d < bright_d))) begin
      led_d = LED_OUTPUT_LEVEL;
    end else begin
      led_d = ~LED_OUTPUT_LEVEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      repeat_q    <= 1'b0;
      bright_q    <= '0;
      pwm_cnt_q   <= '0;
      led_q       <= ~LED_OUTPUT_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      repeat_q    <= repeat_d;
      bright_q    <= bright_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_led_blink_signaler.sv
// Directed testbench for led_blink_signaler.
// Timing: ON = 20 clocks, OFF = 10 clocks, GAP = 30 clocks, 2-bit PWM.
// Cycle c counts from the acceptance cycle (c = 0); outputs are sampled
// 1 time unit after each rising edge.
module tb_led_blink_signaler;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_count;
  logic       req_repeat;
  logic [1:0] req_brightness;
  logic       led;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  led_blink_signaler #(
    .CLK_FREQUENCY    (10000),
    .LED_OUTPUT_LEVEL (1'b1),
    .ON_MS            (2),
    .OFF_MS           (1),
    .GAP_MS           (3),
    .CNT_W            (4),
    .PWM_W            (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_count      (req_count),
    .req_repeat     (req_repeat),
    .req_brightness (req_brightness),
    .led            (led),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    req_count = 4'd0;
    req_repeat = 1'b0;
    req_brightness = 2'd0;
    step_cycle();
    step_cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (led !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_led c=%0d got %b want 0", c, led);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_busy c=%0d got %b want 0", c, busy);
      end
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_done c=%0d got %b want 0", c, done);
      end
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_ready c=%0d got %b want 1", c, req_ready);
      end
      step_cycle();
    end
  endtask

  task automatic test_one_shot();
    logic exp_led, exp_done, exp_busy;
    req_count = 4'd3;
    req_repeat = 1'b0;
    req_brightness = 2'd3;
    req_valid = 1'b1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL oneshot_ready c=0 got %b want 1", req_ready);
    end
    for (int c = 1; c <= 95; c++) begin
      step_cycle();
      if (c == 1) req_valid = 1'b0;
      exp_led  = ((c >= 1) && (c <= 20)) || ((c >= 31) && (c <= 50)) ||
                 ((c >= 61) && (c <= 80));
      exp_done = (c == 91);
      exp_busy = (c < 91);
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL oneshot_led c=%0d got %b want %b", c, led, exp_led);
      end
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL oneshot_done c=%0d got %b want %b", c, done, exp_done);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL oneshot_busy c=%0d got %b want %b", c, busy, exp_busy);
      end
    end
  endtask

  task automatic test_repeat_and_stop();
    logic exp_led, exp_busy;
    req_count = 4'd1;
    req_repeat = 1'b1;
    req_brightness = 2'd3;
    req_valid = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      step_cycle();
      if (c == 1) req_valid = 1'b0;
      if (c == 70) begin
        req_valid = 1'b1;
        req_count = 4'd0;
        req_repeat = 1'b0;
      end
      if (c == 71) req_valid = 1'b0;
      exp_led  = ((c >= 1) && (c <= 20)) || ((c >= 61) && (c <= 70));
      exp_busy = (c <= 70);
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL repeat_led c=%0d got %b want %b", c, led, exp_led);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL repeat_busy c=%0d got %b want %b", c, busy, exp_busy);
      end
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL repeat_done c=%0d got %b want 0", c, done);
      end
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL repeat_ready c=%0d got %b want 1", c, req_ready);
      end
    end
  endtask

  task automatic test_pwm();
    int lit;
    int last_lit;
    // Brightness 1 on a 2-bit PWM: one lit cycle in every four.
    req_count = 4'd1;
    req_repeat = 1'b0;
    req_brightness = 2'd1;
    req_valid = 1'b1;
    lit = 0;
    last_lit = -1;
    for (int c = 1; c <= 31; c++) begin
      step_cycle();
      if (c == 1) req_valid = 1'b0;
      if (led === 1'b1) begin
        lit++;
        vectors++;
        if (c > 20) begin
          miscompares++;
          $display("[TB] FAIL pwm_lit_outside_on c=%0d got 1 want 0", c);
        end
        if (last_lit >= 0) begin
          vectors++;
          if (c - last_lit != 4) begin
            miscompares++;
            $display("[TB] FAIL pwm_spacing c=%0d got %0d want 4", c, c - last_lit);
          end
        end
        last_lit = c;
      end
      vectors++;
      if (done !== (c == 31)) begin
        miscompares++;
        $display("[TB] FAIL pwm1_done c=%0d got %b want %b", c, done, (c == 31));
      end
    end
    vectors++;
    if (lit != 5) begin
      miscompares++;
      $display("[TB] FAIL pwm1_lit_count got %0d want 5", lit);
    end
    step_cycle();
    step_cycle();
    // Brightness 0: dark throughout, timing unchanged.
    req_brightness = 2'd0;
    req_valid = 1'b1;
    lit = 0;
    for (int c = 1; c <= 33; c++) begin
      step_cycle();
      if (c == 1) req_valid = 1'b0;
      if (led !== 1'b0) lit++;
      vectors++;
      if (done !== (c == 31)) begin
        miscompares++;
        $display("[TB] FAIL pwm0_done c=%0d got %b want %b", c, done, (c == 31));
      end
      vectors++;
      if (busy !== (c < 31)) begin
        miscompares++;
        $display("[TB] FAIL pwm0_busy c=%0d got %b want %b", c, busy, (c < 31));
      end
    end
    vectors++;
    if (lit != 0) begin
      miscompares++;
      $display("[TB] FAIL pwm0_lit_count got %0d want 0", lit);
    end
  endtask

  task automatic test_ignore_then_reset();
    logic exp_ready;
    req_count = 4'd2;
    req_repeat = 1'b0;
    req_brightness = 2'd3;
    req_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step_cycle();
      if (c == 1) req_valid = 1'b0;
      if (c == 5) begin
        req_valid = 1'b1;
        req_count = 4'd5;
        req_repeat = 1'b1;
        req_brightness = 2'd0;
      end
      if (c == 6) req_valid = 1'b0;
      if (c == 10) reset = 1'b1;
      vectors++;
      if (req_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ignore_ready c=%0d got %b want 0", c, req_ready);
      end
      vectors++;
      if (led !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL ignore_led c=%0d got %b want 1", c, led);
      end
    end
    for (int c = 11; c <= 45; c++) begin
      step_cycle();
      reset = 1'b0;
      exp_ready = 1'b1;
      vectors++;
      if (led !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_led c=%0d got %b want 0", c, led);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_busy c=%0d got %b want 0", c, busy);
      end
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_done c=%0d got %b want 0", c, done);
      end
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_ready c=%0d got %b want %b", c, req_ready, exp_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_led, exp_done, exp_busy, exp_ready;
    req_count = 4'd1;
    req_repeat = 1'b0;
    req_brightness = 2'd3;
    req_valid = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      step_cycle();
      if (c == 32) req_valid = 1'b0;
      exp_led   = ((c >= 1) && (c <= 20)) || ((c >= 32) && (c <= 51));
      exp_done  = (c == 31) || (c == 62);
      exp_busy  = (c <= 30) || ((c >= 32) && (c <= 61));
      exp_ready = !exp_busy;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("[TB] FAIL b2b_led c=%0d got %b want %b", c, led, exp_led);
      end
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL b2b_done c=%0d got %b want %b", c, done, exp_done);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL b2b_busy c=%0d got %b want %b", c, busy, exp_busy);
      end
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready c=%0d got %b want %b", c, req_ready, exp_ready);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_one_shot();
    step_cycle();
    test_repeat_and_stop();
    step_cycle();
    test_pwm();
    step_cycle();
    test_ignore_then_reset();
    step_cycle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
